// File: rtl/winograd_tile_feeder.sv
// ---------------------------------------------------------------------------
// winograd_tile_feeder
//
// Upstream stage of winograd2d. Buffers a raster-order pixel stream in a
// 4-row circular line store and replays it as overlapping 4x4 tiles
// (stride 2), one 4-pixel column per output transfer, with tile/band/frame
// framing flags for the downstream control logic.
//
// Ports:
//   clk, rst              clock (rising edge) and async active-high reset
//   in_valid/in_ready     input handshake, in_pix is the raster pixel
//   out_valid/out_ready   output handshake for one tile column
//   r1_x..r4_x            tile column lanes, r1_x is the oldest (top) row
//   tile_first/tile_last  column 0 / column 3 of the current tile
//   band_last             last column of the last tile in a band
//   frame_last            last column of the frame
// ---------------------------------------------------------------------------
module winograd_tile_feeder #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] r1_x,
    output logic [DATA_W-1:0] r2_x,
    output logic [DATA_W-1:0] r3_x,
    output logic [DATA_W-1:0] r4_x,
    output logic              tile_first,
    output logic              tile_last,
    output logic              band_last,
    output logic              frame_last
);

    localparam int LAST_TILE_I = (IMG_W - 4) / 2;
    localparam int LAST_BAND_I = (IMG_H - 4) / 2;
    localparam int COL_W       = $clog2(IMG_W);
    localparam int TILE_W      = (LAST_TILE_I > 0) ? $clog2(LAST_TILE_I + 1) : 1;
    localparam int BAND_W      = (LAST_BAND_I > 0) ? $clog2(LAST_BAND_I + 1) : 1;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(LAST_TILE_I);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(LAST_BAND_I);

    typedef enum logic [1:0] {
        FILL_INIT,
        EMIT,
        FILL_NEXT
    } feederState_t;

    feederState_t r_state;
    feederState_t w_nextState;

    logic [DATA_W-1:0] r_store [4][IMG_W];

    logic [1:0]        r_wrRow;
    logic [COL_W-1:0]  r_wrCol;
    logic [1:0]        r_fillRows;
    logic [1:0]        r_topRow;
    logic [1:0]        r_tileCol;
    logic [TILE_W-1:0] r_tile;
    logic [BAND_W-1:0] r_band;

    logic              w_inXfer;
    logic              w_outXfer;
    logic              w_fillDone;
    logic              w_bandDone;
    logic              w_frameDone;
    logic [COL_W-1:0]  w_rdCol;
    logic [1:0]        w_row2;
    logic [1:0]        w_row3;
    logic [1:0]        w_row4;

    // Handshakes. The feeder either fills or emits, never both, so the two
    // transfer strobes are mutually exclusive. in_ready is also forced low
    // while reset is held so the input side looks idle during reset.
    assign in_ready  = !rst && (r_state != EMIT);
    assign out_valid = (r_state == EMIT);
    assign w_inXfer  = in_valid && in_ready;
    assign w_outXfer = out_valid && out_ready;

    // A fill finishes on the last pixel of its last row: four rows for the
    // first band of a frame, two fresh rows for every later band.
    assign w_fillDone  = w_inXfer && (r_wrCol == LAST_COL) &&
                         (r_fillRows == ((r_state == FILL_INIT) ? 2'd3 : 2'd1));
    assign w_bandDone  = w_outXfer && (r_tileCol == 2'd3) && (r_tile == LAST_TILE);
    assign w_frameDone = w_bandDone && (r_band == LAST_BAND);

    // Tile t covers store columns 2t..2t+3; the overlap with the next tile
    // is simply a re-read of the same store columns.
    assign w_rdCol = COL_W'({r_tile, 1'b0}) + COL_W'(r_tileCol);

    // Lane rows are taken relative to the oldest row of the band so the
    // circular rotation of the store is invisible downstream.
    assign w_row2 = r_topRow + 2'd1;
    assign w_row3 = r_topRow + 2'd2;
    assign w_row4 = r_topRow + 2'd3;

    // The store never changes during EMIT, so the combinational read holds
    // steady under backpressure without any output register.
    assign r1_x = out_valid ? r_store[r_topRow][w_rdCol] : '0;
    assign r2_x = out_valid ? r_store[w_row2][w_rdCol]   : '0;
    assign r3_x = out_valid ? r_store[w_row3][w_rdCol]   : '0;
    assign r4_x = out_valid ? r_store[w_row4][w_rdCol]   : '0;

    assign tile_first = out_valid && (r_tileCol == 2'd0);
    assign tile_last  = out_valid && (r_tileCol == 2'd3);
    assign band_last  = tile_last && (r_tile == LAST_TILE);
    assign frame_last = band_last && (r_band == LAST_BAND);

    // Line store write port. Contents carry no reset; every location is
    // rewritten by a fill before it is ever read.
    always_ff @(posedge clk) begin
        if (w_inXfer) begin
            r_store[r_wrRow][r_wrCol] <= in_pix;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fill until enough rows are present, emit a whole
    // band, then either top up two rows or start the next frame.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL_INIT, FILL_NEXT: begin
                if (w_fillDone) begin
                    w_nextState = EMIT;
                end
            end
            EMIT: begin
                if (w_frameDone) begin
                    w_nextState = FILL_INIT;
                end else if (w_bandDone) begin
                    w_nextState = FILL_NEXT;
                end
            end
            default: w_nextState = FILL_INIT;
        endcase
    end

    // Write pointer, fill row count, and the tile/band position counters.
    // At the end of a band the oldest two rows are retired by advancing the
    // top row by two; a new frame restarts the store at physical row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrRow    <= '0;
            r_wrCol    <= '0;
            r_fillRows <= '0;
            r_topRow   <= '0;
            r_tileCol  <= '0;
            r_tile     <= '0;
            r_band     <= '0;
        end else begin
            if (w_inXfer) begin
                if (r_wrCol == LAST_COL) begin
                    r_wrCol    <= '0;
                    r_wrRow    <= r_wrRow + 2'd1;
                    r_fillRows <= w_fillDone ? 2'd0 : (r_fillRows + 2'd1);
                end else begin
                    r_wrCol <= r_wrCol + COL_W'(1);
                end
            end
            if (w_outXfer) begin
                if (r_tileCol == 2'd3) begin
                    r_tileCol <= '0;
                    if (r_tile == LAST_TILE) begin
                        r_tile <= '0;
                        if (r_band == LAST_BAND) begin
                            r_band   <= '0;
                            r_wrRow  <= '0;
                            r_topRow <= '0;
                        end else begin
                            r_band   <= r_band + BAND_W'(1);
                            r_topRow <= r_topRow + 2'd2;
                        end
                    end else begin
                        r_tile <= r_tile + TILE_W'(1);
                    end
                end else begin
                    r_tileCol <= r_tileCol + 2'd1;
                end
            end
        end
    end

endmodule
